mem_port_arbiter: RTL and testbench

- Shares the single SDRAM controller bus port among NUM_MASTERS requesters: master 0 = debug controller, 1 = CPU data port, 2 = CPU instruction fetch.
- Sits in the SoC between the CPU/debug bus masters and the SDRAM controller.
- Uses the same access/ack handshake as the rest of the SoC bus.
- Grants are round-robin, one outstanding transaction at a time, with a watchdog that aborts a hung slave.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_rr_picker.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter:
// FSM encoding, master indices and a width helper.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MASTER_DBG    = 0;
    localparam int MASTER_DATA   = 1;
    localparam int MASTER_IFETCH = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin priority selector: first requester at or
// after ptr, searching cyclically through N requesters.
module mem_port_arbiter_rr_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int          c;
    logic [IW-1:0] cidx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        cidx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            cidx = IW'(c);
            if (req[cidx]) begin
                valid = 1'b1;
                idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the SDRAM controller port among bus masters:
// round-robin grant, one transaction in flight, watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 1023,
    parameter int TO_W        = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS-1:0]    m_access,
    input  logic [NUM_MASTERS-1:0]    m_wr_en,
    input  logic [NUM_MASTERS*30-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wr_val,
    input  logic [NUM_MASTERS*4-1:0]  m_bytesel,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic                      m_error,
    output logic [31:0]               m_data,
    output logic                      s_access,
    output logic                      s_wr_en,
    output logic [29:0]               s_addr,
    output logic [31:0]               s_wr_val,
    output logic [3:0]                s_bytesel,
    input  logic                      s_ack,
    input  logic [31:0]               s_data
);

    localparam int GW = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            s_access_q, s_access_d;
    logic            s_wr_en_q, s_wr_en_d;
    logic [29:0]     s_addr_q, s_addr_d;
    logic [31:0]     s_wr_val_q, s_wr_val_d;
    logic [3:0]      s_bytesel_q, s_bytesel_d;

    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic            busy, done, timed_out, finish;
    logic [GW-1:0]   ptr_next;

    mem_port_arbiter_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (GW)
    ) u_picker (
        .req   (m_access),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy      = (state_q == ARB_BUSY);
    assign done      = busy && s_ack;
    assign timed_out = busy && !s_ack && (TIMEOUT != 0)
                       && (cnt_q == TO_W'(TIMEOUT));
    assign finish    = done || timed_out;
    assign ptr_next  = (grant_q == GW'(NUM_MASTERS - 1))
                       ? '0 : grant_q + GW'(1);

    // Next-state: grant and latch in IDLE, count and retire in BUSY.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        s_access_d  = s_access_q;
        s_wr_en_d   = s_wr_en_q;
        s_addr_d    = s_addr_q;
        s_wr_val_d  = s_wr_val_q;
        s_bytesel_d = s_bytesel_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d     = ARB_BUSY;
                    grant_d     = pick_idx;
                    cnt_d       = '0;
                    s_access_d  = 1'b1;
                    s_wr_en_d   = m_wr_en[pick_idx];
                    s_addr_d    = m_addr[int'(pick_idx)*30 +: 30];
                    s_wr_val_d  = m_wr_val[int'(pick_idx)*32 +: 32];
                    s_bytesel_d = m_bytesel[int'(pick_idx)*4 +: 4];
                end
            end
            ARB_BUSY: begin
                if (finish) begin
                    state_d    = ARB_IDLE;
                    s_access_d = 1'b0;
                    rr_ptr_d   = ptr_next;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and slave-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            s_access_q  <= 1'b0;
            s_wr_en_q   <= 1'b0;
            s_addr_q    <= '0;
            s_wr_val_q  <= '0;
            s_bytesel_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            s_access_q  <= s_access_d;
            s_wr_en_q   <= s_wr_en_d;
            s_addr_q    <= s_addr_d;
            s_wr_val_q  <= s_wr_val_d;
            s_bytesel_q <= s_bytesel_d;
        end
    end

    // Completion is routed combinationally to the granted master.
    always_comb begin
        m_ack   = '0;
        m_error = 1'b0;
        m_data  = '0;
        if (finish) begin
            m_ack[grant_q] = 1'b1;
            m_error        = timed_out;
            m_data         = done ? s_data : 32'h0;
        end
    end

    assign s_access  = s_access_q;
    assign s_wr_en   = s_wr_en_q;
    assign s_addr    = s_addr_q;
    assign s_wr_val  = s_wr_val_q;
    assign s_bytesel = s_bytesel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus corner
// sequences, with a scoreboard of expected master acks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int TW = 4;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_access, m_wr_en, m_ack;
    logic [N*30-1:0] m_addr;
    logic [N*32-1:0] m_wr_val;
    logic [N*4-1:0]  m_bytesel;
    logic            m_error;
    logic [31:0]     m_data;
    logic            s_access, s_wr_en, s_ack;
    logic [29:0]     s_addr;
    logic [31:0]     s_wr_val, s_data;
    logic [3:0]      s_bytesel;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TO),
        .TO_W        (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_access  (m_access),
        .m_wr_en   (m_wr_en),
        .m_addr    (m_addr),
        .m_wr_val  (m_wr_val),
        .m_bytesel (m_bytesel),
        .m_ack     (m_ack),
        .m_error   (m_error),
        .m_data    (m_data),
        .s_access  (s_access),
        .s_wr_en   (s_wr_en),
        .s_addr    (s_addr),
        .s_wr_val  (s_wr_val),
        .s_bytesel (s_bytesel),
        .s_ack     (s_ack),
        .s_data    (s_data)
    );

    typedef struct {
        logic [N-1:0] mask;
        logic         wr;
        int           delay;
        logic [29:0]  addr;
        logic [31:0]  data;
        int           exp_g;
    } vec_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          ack_delay, scnt, low_cnt;
    logic [31:0] rd_val;
    logic [N-1:0] ack_seen;
    logic        cont_mode, gap_chk, had_pulse, prev_acc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Scoreboard: every ack must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_ack != '0) begin
                chk("ack_onehot", 64'($countones(m_ack)), 64'd1);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 64'(m_ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_idx", 64'(idx_of(m_ack)), 64'(e.idx));
                    chk("ack_err", 64'(m_error), 64'(e.err));
                    chk("ack_data", 64'(m_data), 64'(e.data));
                end
                ack_seen = ack_seen | m_ack;
            end else if (m_error || m_data != 0) begin
                chk("idle_outputs", {31'd0, m_error, m_data}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (ack_seen[i] && !cont_mode) m_access[i] = 1'b0;
        ack_seen = '0;
        if (s_ack) begin
            s_ack = 1'b0; s_data = JUNK; scnt = 0;
        end else if (s_access) begin
            scnt++;
            if (scnt > ack_delay) begin
                s_ack = 1'b1; s_data = rd_val;
            end
        end else begin
            scnt = 0;
        end
        if (gap_chk) begin
            if (!s_access) low_cnt++;
            else if (!prev_acc && had_pulse)
                chk("idle_gap", 64'(low_cnt), 64'd1);
            if (s_access) begin
                had_pulse = 1'b1; low_cnt = 0;
            end
        end
        prev_acc = s_access;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 60) begin
            tick(); t++;
        end
        if (sbq.size() != 0) begin
            chk({"no_ack_", nm}, 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_ack"}, {60'd0, m_ack, m_error}, 64'd0);
        chk({nm, "_mdata"}, 64'(m_data), 64'd0);
        chk({nm, "_sctl"}, {62'd0, s_access, s_wr_en}, 64'd0);
        chk({nm, "_saddr"}, {30'd0, s_addr, s_bytesel}, 64'd0);
        chk({nm, "_swval"}, 64'(s_wr_val), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        m_access = '0;
        rst_n = 1'b0;
        #3;
        chk_outputs_zero(nm);
        s_ack = 1'b0; s_data = JUNK; scnt = 0;
        sbq.delete(); ack_seen = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_acc = 1'b0;
    endtask

    task automatic set_master(input int i, input logic wr,
                              input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        m_wr_en[i]          = wr;
        m_addr[i*30 +: 30]  = a;
        m_wr_val[i*32 +: 32] = d;
        m_bytesel[i*4 +: 4] = be;
    endtask

    function automatic exp_t mk(input int i, input logic e,
                                input logic [31:0] d);
        exp_t x;
        x.idx = i; x.err = e; x.data = d;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{3'b010, 1'b0, 3, 30'h100,     32'hDEADBEEF, MASTER_DATA};
        vecs[1] = '{3'b011, 1'b1, 0, 30'h2000,    32'h0000_1111, MASTER_DBG};
        vecs[2] = '{3'b101, 1'b0, 1, 30'h3FFF_FFF, 32'hA5A5_5A5A, MASTER_IFETCH};
        vecs[3] = '{3'b111, 1'b0, 2, 30'h0,       32'hFFFF_FFFF, MASTER_DBG};
        vecs[4] = '{3'b100, 1'b1, 4, 30'h1234,    32'h0F0F_0F0F, MASTER_IFETCH};
        vecs[5] = '{3'b110, 1'b0, 1, 30'h55,      32'h8000_0001, MASTER_DATA};
        vecs[6] = '{3'b001, 1'b0, 0, 30'h77,      32'h1357_9BDF, MASTER_DBG};
        vecs[7] = '{3'b101, 1'b1, 2, 30'h2AAA_AAA, 32'h2468_ACE0, MASTER_IFETCH};

        m_access = '0; m_wr_en = '0; m_addr = '0;
        m_wr_val = '0; m_bytesel = '0;
        s_ack = 1'b0; s_data = JUNK; rd_val = 0;
        ack_delay = 1; scnt = 0; ack_seen = '0;
        cont_mode = 1'b0; gap_chk = 1'b0;
        had_pulse = 1'b0; prev_acc = 1'b0; low_cnt = 0;
        do_reset("reset");

        // All masters requesting continuously from reset.
        for (int i = 0; i < N; i++)
            set_master(i, 1'b0, 30'(i + 16), 32'(i), 4'hF);
        ack_delay = 1; rd_val = 32'hC0DE_0000;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) sbq.push_back(mk(i, 1'b0, rd_val));
        cont_mode = 1'b1; gap_chk = 1'b1;
        had_pulse = 1'b0; low_cnt = 0;
        m_access = '1;
        wait_done("rr_cont");
        m_access = '0;
        cont_mode = 1'b0; gap_chk = 1'b0;

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                if (i == vecs[v].exp_g)
                    set_master(i, vecs[v].wr, vecs[v].addr,
                               vecs[v].data, 4'hF);
                else
                    set_master(i, ~vecs[v].wr, ~vecs[v].addr,
                               ~vecs[v].data, 4'h0);
            end
            ack_delay = vecs[v].delay;
            rd_val = vecs[v].data ^ 32'h0101_0101;
            sbq.push_back(mk(vecs[v].exp_g, 1'b0, rd_val));
            m_access = vecs[v].mask;
            tick();
            chk("vec_latency", 64'(s_access), 64'd1);
            chk("vec_saddr", 64'(s_addr), 64'(vecs[v].addr));
            chk("vec_swval", {31'd0, s_wr_en, s_wr_val},
                {31'd0, vecs[v].wr, vecs[v].data});
            wait_done("vec");
            m_access = '0;
        end

        // Master 2 write; inputs change while busy.
        set_master(2, 1'b1, 30'h2_AAAA, 32'h1234_5678, 4'b0011);
        ack_delay = 5; rd_val = 32'h0;
        sbq.push_back(mk(2, 1'b0, rd_val));
        m_access = 3'b100;
        tick();
        set_master(2, 1'b0, 30'h1_5555, 32'h8765_4321, 4'b1100);
        for (int t = 0; t < 3; t++) begin
            chk("hold_saddr", {34'd0, s_addr}, {34'd0, 30'h2_AAAA});
            chk("hold_swval", 64'(s_wr_val), 64'h1234_5678);
            chk("hold_ctl", {58'd0, s_access, s_wr_en, s_bytesel},
                {58'd0, 1'b1, 1'b1, 4'b0011});
            tick();
        end
        wait_done("hold");

        // Master 0 withdraws before completion; ack still comes.
        set_master(0, 1'b0, 30'h40, 32'h0, 4'hF);
        ack_delay = 3; rd_val = 32'h0BAD_F00D;
        sbq.push_back(mk(0, 1'b0, rd_val));
        m_access = 3'b001;
        tick();
        chk("drop_sacc", 64'(s_access), 64'd1);
        m_access[0] = 1'b0;
        wait_done("drop");
        set_master(1, 1'b0, 30'h41, 32'h0, 4'hF);
        ack_delay = 1; rd_val = 32'h1111_2222;
        sbq.push_back(mk(1, 1'b0, rd_val));
        m_access = 3'b011;
        tick();
        chk("drop_next_addr", 64'(s_addr), 64'h41);
        wait_done("drop_next");
        m_access = '0;

        // Watchdog expiry and a late s_ack.
        set_master(0, 1'b0, 30'hDD, 32'h0, 4'hF);
        ack_delay = 1000;
        sbq.push_back(mk(0, 1'b1, 32'h0));
        m_access = 3'b001;
        tick();
        chk("to_sacc", 64'(s_access), 64'd1);
        for (int t = 1; t <= TO - 1; t++) tick();
        chk("to_early", 64'(m_ack), 64'd0);
        tick();
        chk("to_ack", {60'd0, m_ack, m_error}, {60'd0, 3'b001, 1'b1});
        tick();
        chk("to_sacc_drop", 64'(s_access), 64'd0);
        s_ack = 1'b1; s_data = 32'h55AA_55AA;
        #1;
        chk("late_ack", {31'd0, m_ack, m_data}, 64'd0);
        tick();
        tick();
        chk("late_idle", 64'(s_access), 64'd0);
        if (sbq.size() != 0) begin
            chk("to_missing", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end

        // Reset in the middle of a transaction.
        set_master(1, 1'b0, 30'h99, 32'h0, 4'hF);
        ack_delay = 1000;
        sbq.push_back(mk(1, 1'b0, 32'h0));
        m_access = 3'b010;
        repeat (3) tick();
        chk("pre_rst_sacc", 64'(s_access), 64'd1);
        do_reset("mid_rst");
        for (int i = 0; i < N; i++)
            set_master(i, 1'b0, 30'(i + 200), 32'h0, 4'hF);
        ack_delay = 2; rd_val = 32'hFEED_0000;
        sbq.push_back(mk(0, 1'b0, rd_val));
        m_access = '1;
        tick();
        chk("post_rst_addr", 64'(s_addr), 64'd200);
        wait_done("post_rst");
        m_access = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
